// File: rtl/capture_sequencer_if.sv
// Signal bundle between the capture sequencer, the ADC sample source,
// the ping-pong sample RAM write port and the analysis-core frame handshake.
// The master modport is the sequencer's view; the slave modport is the
// view of the surrounding ADC/RAM/core environment.
interface capture_sequencer_if #(
    parameter int FRAME_LEN = 1024
) ();
    localparam int ADDR_W = $clog2(FRAME_LEN) + 1;

    logic [11:0]        adc_data;
    logic               adc_data_valid;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic signed [11:0] wr_data;
    logic               frame_ready;
    logic               frame_bank;
    logic               core_done;

    modport master (
        input  adc_data,
        input  adc_data_valid,
        input  core_done,
        output wr_en,
        output wr_addr,
        output wr_data,
        output frame_ready,
        output frame_bank
    );

    modport slave (
        output adc_data,
        output adc_data_valid,
        output core_done,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  frame_ready,
        input  frame_bank
    );
endinterface

// File: rtl/capture_sequencer.sv
// Audio capture sequencer: decimates the 12-bit unsigned ADC stream by block
// averaging, converts each average to signed two's complement, writes frames
// of FRAME_LEN samples into a ping-pong sample RAM and hands each completed
// frame to the analysis core via a frame_ready/core_done handshake.
module capture_sequencer #(
    parameter int DECIM      = 4,
    parameter int FRAME_LEN  = 1024,
    parameter int NUM_FRAMES = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    capture_sequencer_if.master bus,
    output logic                busy,
    output logic                rec_done,
    output logic                overrun
);
    localparam int LOG2D  = $clog2(DECIM);
    localparam int ACC_W  = 12 + LOG2D;
    localparam int CNT_W  = (LOG2D > 0) ? LOG2D : 1;
    localparam int IDX_W  = $clog2(FRAME_LEN);
    localparam int ADDR_W = IDX_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DECIM - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(FRAME_LEN - 1);
    localparam logic [7:0]       FRAMES_LAST = 8'(NUM_FRAMES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    // Start synchronizer / edge detector
    logic start_meta;
    logic start_sync;
    logic start_prev;
    logic start_pulse;

    // Control state
    logic [1:0] state;
    logic       bank;
    logic [7:0] frame_cnt;
    logic       frame_ready_q;
    logic       frame_bank_q;

    // Datapath state
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  dec_cnt;
    logic [IDX_W-1:0]  index;
    logic              last_wr;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [11:0]       wr_data_q;

    // Combinational helpers
    logic [ACC_W-1:0] acc_sum;
    logic [11:0]      avg;
    logic             start_accept;
    logic             frame_end;
    logic             ack;
    logic             can_publish;
    logic             last_frame;
    logic             keep_capturing;
    logic             cur_bank;
    logic             take_sample;
    logic             group_done;

    assign acc_sum      = acc + ACC_W'(bus.adc_data);
    assign avg          = 12'(acc_sum >> LOG2D);
    assign start_accept = (state == ST_IDLE) && start_pulse;

    // A frame completes in the cycle after the write of its last index.
    assign frame_end   = (state == ST_CAPTURE) && wr_en_q && last_wr;
    assign ack         = bus.core_done && frame_ready_q;
    assign can_publish = !frame_ready_q || ack;
    assign last_frame  = (frame_cnt == FRAMES_LAST);

    // A sample arriving in the frame-completion cycle already belongs to the
    // next bank, and is dropped if that completion ends the capture (overrun
    // or final frame). Only matters for DECIM=1, where every valid writes.
    assign keep_capturing = (state == ST_CAPTURE) &&
                            !(frame_end && (!can_publish || last_frame));
    assign cur_bank    = frame_end ? ~bank : bank;
    assign take_sample = keep_capturing && bus.adc_data_valid;
    assign group_done  = take_sample && (dec_cnt == CNT_LAST);

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.frame_bank  = frame_bank_q;

    // Two-stage synchronizer on the push-button start, then a registered rising-edge pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_meta  <= 1'b0;
            start_sync  <= 1'b0;
            start_prev  <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            start_meta  <= start;
            start_sync  <= start_meta;
            start_prev  <= start_sync;
            start_pulse <= start_sync & ~start_prev;
        end
    end

    // Decimation accumulator and sample RAM write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            dec_cnt   <= '0;
            index     <= '0;
            last_wr   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (start_accept) begin
                acc     <= '0;
                dec_cnt <= '0;
                index   <= '0;
                last_wr <= 1'b0;
            end else if (take_sample) begin
                if (group_done) begin
                    // Group complete: emit the average and restart the accumulator.
                    acc       <= '0;
                    dec_cnt   <= '0;
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= {cur_bank, index};
                    wr_data_q <= avg - 12'h800;
                    last_wr   <= (index == IDX_LAST);
                    index     <= index + IDX_W'(1);
                end else begin
                    acc     <= acc_sum;
                    dec_cnt <= dec_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Recording FSM, bank ping-pong and frame handshake with the analysis core
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            bank          <= 1'b0;
            frame_cnt     <= '0;
            frame_ready_q <= 1'b0;
            frame_bank_q  <= 1'b0;
            busy          <= 1'b0;
            rec_done      <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            rec_done <= 1'b0;

            // Release of the pending frame; a publish below in the same cycle overrides it.
            if (ack) begin
                frame_ready_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start_pulse) begin
                        state     <= ST_CAPTURE;
                        busy      <= 1'b1;
                        overrun   <= 1'b0;
                        bank      <= 1'b0;
                        frame_cnt <= '0;
                    end
                end

                ST_CAPTURE: begin
                    if (frame_end) begin
                        if (can_publish) begin
                            frame_ready_q <= 1'b1;
                            frame_bank_q  <= bank;
                            bank          <= ~bank;
                            frame_cnt     <= frame_cnt + 8'd1;
                            if (last_frame) begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            overrun <= 1'b1;
                            busy    <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (ack) begin
                        rec_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer (DECIM=2, FRAME_LEN=4, NUM_FRAMES=3).
// Decimation vectors come from a table of {adc pair, expected sample, expected address};
// the handshake, overrun, simultaneous-ack and abort cases are hand-written sequences.
module tb_capture_sequencer;
    localparam int DECIM      = 2;
    localparam int FRAME_LEN  = 4;
    localparam int NUM_FRAMES = 3;

    typedef struct {
        int a0;
        int a1;
        int exp_data;
        int exp_addr;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic rec_done;
    logic overrun;

    int tests = 0;
    int fails = 0;
    vec_t vecs[12];

    capture_sequencer_if #(.FRAME_LEN(FRAME_LEN)) bus ();

    capture_sequencer #(
        .DECIM      (DECIM),
        .FRAME_LEN  (FRAME_LEN),
        .NUM_FRAMES (NUM_FRAMES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .rec_done (rec_done),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_done();
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
    endtask

    task automatic start_recording();
        start = 1'b1;
        repeat (3) tick();
        check("busy_before_accept", int'(busy), 0);
        tick();
        check("busy_after_accept", int'(busy), 1);
        start = 1'b0;
        repeat (2) tick();
        check("no_wr_before_valid", int'(bus.wr_en), 0);
    endtask

    // Feed one valid pair, wait (bounded) for the write, check it, then step one
    // more cycle, optionally acknowledging the pending frame in the write cycle.
    task automatic run_vec(input int idx, input bit ack_on_write);
        int waited;
        bus.adc_data_valid = 1'b1;
        bus.adc_data       = 12'(vecs[idx].a0);
        tick();
        bus.adc_data       = 12'(vecs[idx].a1);
        tick();
        bus.adc_data_valid = 1'b0;
        bus.adc_data       = '0;
        waited = 0;
        while (!bus.wr_en && waited < 8) begin
            tick();
            waited++;
        end
        check($sformatf("wr_latency[%0d]", idx), waited, 0);
        check($sformatf("wr_data[%0d]", idx), int'(bus.wr_data), vecs[idx].exp_data);
        check($sformatf("wr_addr[%0d]", idx), int'(bus.wr_addr), vecs[idx].exp_addr);
        if (ack_on_write) bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        check($sformatf("wr_en_width[%0d]", idx), int'(bus.wr_en), 0);
    endtask

    initial begin
        int seen;

        // frame 0 (bank 0)
        vecs[0]  = '{4095, 4095,  2047, 0};
        vecs[1]  = '{   0,    0, -2048, 1};
        vecs[2]  = '{2048, 2049,     0, 2};
        vecs[3]  = '{   1,    2, -2047, 3};
        // frame 1 (bank 1)
        vecs[4]  = '{ 100,  102, -1947, 4};
        vecs[5]  = '{4000, 4001,  1952, 5};
        vecs[6]  = '{2047, 2048,    -1, 6};
        vecs[7]  = '{3000, 3000,   952, 7};
        // frame 2 (bank 0)
        vecs[8]  = '{  10,   11, -2038, 0};
        vecs[9]  = '{4094, 4095,  2046, 1};
        vecs[10] = '{2050, 2052,     3, 2};
        vecs[11] = '{ 500,  700, -1448, 3};

        bus.adc_data       = '0;
        bus.adc_data_valid = 1'b0;
        bus.core_done      = 1'b0;

        // Reset held with start toggling
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            start = (i % 2 == 1);
            tick();
        end
        start = 1'b0;
        check("reset_outputs", int'({bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_ready,
                                     bus.frame_bank, busy, rec_done, overrun}), 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (4) tick();
        check("idle_after_release", int'(busy), 0);

        // Full recording with timely acknowledgements
        start_recording();
        for (int j = 0; j < 4; j++) run_vec(j, 1'b0);
        check("f0_ready", int'(bus.frame_ready), 1);
        check("f0_bank", int'(bus.frame_bank), 0);
        repeat (4) tick();
        pulse_done();
        check("f0_released", int'(bus.frame_ready), 0);
        for (int j = 4; j < 8; j++) run_vec(j, 1'b0);
        check("f1_ready", int'(bus.frame_ready), 1);
        check("f1_bank", int'(bus.frame_bank), 1);
        pulse_done();
        check("f1_released", int'(bus.frame_ready), 0);
        for (int j = 8; j < 12; j++) run_vec(j, 1'b0);
        check("f2_ready", int'(bus.frame_ready), 1);
        check("f2_bank", int'(bus.frame_bank), 0);
        check("drain_busy", int'(busy), 1);
        check("drain_no_rec_done", int'(rec_done), 0);

        // Valids in DRAIN produce no writes
        seen = 0;
        bus.adc_data_valid = 1'b1;
        bus.adc_data       = 12'd4095;
        repeat (2) begin
            tick();
            if (bus.wr_en) seen++;
        end
        bus.adc_data_valid = 1'b0;
        repeat (3) begin
            tick();
            if (bus.wr_en) seen++;
        end
        check("drain_ignores_valid", seen, 0);

        pulse_done();
        check("rec_done_pulse", int'(rec_done), 1);
        check("rec_end_busy", int'(busy), 0);
        check("rec_end_ready", int'(bus.frame_ready), 0);
        tick();
        check("rec_done_width", int'(rec_done), 0);

        // Overrun: frame 0 never acknowledged
        repeat (3) tick();
        start_recording();
        for (int j = 0; j < 4; j++) run_vec(j, 1'b0);
        check("ov_f0_ready", int'(bus.frame_ready), 1);
        for (int j = 4; j < 8; j++) run_vec(j, 1'b0);
        check("ov_flag", int'(overrun), 1);
        check("ov_busy", int'(busy), 0);
        check("ov_ready_held", int'(bus.frame_ready), 1);
        check("ov_bank_held", int'(bus.frame_bank), 0);
        repeat (3) tick();
        check("ov_sticky", int'(overrun), 1);
        pulse_done();
        check("ov_idle_release", int'(bus.frame_ready), 0);
        check("ov_survives_ack", int'(overrun), 1);
        repeat (2) tick();
        start_recording();
        check("ov_cleared_by_start", int'(overrun), 0);

        // Ack in the same cycle frame 1 completes
        for (int j = 0; j < 4; j++) run_vec(j, 1'b0);
        for (int j = 4; j < 7; j++) run_vec(j, 1'b0);
        run_vec(7, 1'b1);
        check("sim_ack_no_overrun", int'(overrun), 0);
        check("sim_ack_ready", int'(bus.frame_ready), 1);
        check("sim_ack_bank", int'(bus.frame_bank), 1);
        check("sim_ack_busy", int'(busy), 1);

        // Start edge mid-capture is ignored: sample index keeps advancing
        pulse_done();
        run_vec(8, 1'b0);
        start = 1'b1;
        repeat (6) tick();
        start = 1'b0;
        check("start_ignored_busy", int'(busy), 1);
        for (int j = 9; j < 12; j++) run_vec(j, 1'b0);
        check("f2b_ready", int'(bus.frame_ready), 1);
        check("f2b_bank", int'(bus.frame_bank), 0);

        // Reset during DRAIN aborts immediately
        reset = 1'b0;
        #1;
        check("abort_outputs", int'({bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_ready,
                                     bus.frame_bank, busy, rec_done, overrun}), 0);
        pulse_done();
        tick();
        reset = 1'b1;
        seen = 0;
        repeat (4) begin
            tick();
            if (rec_done || busy || bus.frame_ready) seen++;
        end
        check("abort_not_resumed", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
